// File: rtl/cpu_pkg.sv
// Shared CPU datapath defaults and register-file types.
package cpu_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;
    localparam int unsigned DEFAULT_ADDR_W = 4;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

    localparam int unsigned ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: address mux, zero-register
// override and same-cycle write bypass.
module regfile_read_port #(
    parameter int unsigned DATA_W   = cpu_pkg::DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = cpu_pkg::DEFAULT_ADDR_W,
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                rd_addr,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    output logic [DATA_W-1:0]                rd_data
);
    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

    // Zero register takes priority over bypass so writes to r0 stay invisible.
    always_comb begin
        rd_data = regs[rd_addr];
        if (ZERO_REG && (rd_addr == ZERO_A)) begin
            rd_data = '0;
        end else if (BYPASS && wr_en && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two read ports, one write port and a per-register busy
// scoreboard (reserved by decode, cleared by writeback). State moves on negedge clk.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = cpu_pkg::DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = cpu_pkg::DEFAULT_ADDR_W,
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic                  rd_busy_a,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_b,
    output logic                  rd_busy_b,
    input  logic                  rsv_en,
    input  logic [ADDR_W-1:0]     rsv_addr,
    output logic                  rsv_accept,
    output logic [2**ADDR_W-1:0]  busy_vec
);
    import cpu_pkg::*;

    localparam int unsigned       DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d;
    logic                         wr_drop;

    assign wr_drop = ZERO_REG && (wr_addr == ZERO_A);

    // A busy register written this cycle may be reserved again at once.
    always_comb begin
        rsv_accept = rsv_en && (!busy_q[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en && !wr_drop) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Clear then set: a same-cycle reserve wins over the writeback clear.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_accept) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_d[ZERO_A] = 1'b0;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec  = busy_q;
    assign rd_busy_a = busy_q[rd_addr_a];
    assign rd_busy_b = busy_q[rd_addr_b];

    regfile_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_port_a (
        .regs   (regs_q),
        .rd_addr(rd_addr_a),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_data(rd_data_a)
    );

    regfile_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_port_b (
        .regs   (regs_q),
        .rd_addr(rd_addr_b),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_data(rd_data_b)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two 16x16 configurations share stimulus and are
// checked against an array model; a 32-bit x 32 instance gets directed checks.
module tb_regfile_scoreboard;
    import cpu_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    logic      wr_en;
    reg_addr_t wr_addr;
    reg_data_t wr_data;
    reg_addr_t rd_addr_a, rd_addr_b;
    logic      rsv_en;
    reg_addr_t rsv_addr;

    logic [15:0] rda [2];
    logic [15:0] rdb [2];
    logic        bza [2];
    logic        bzb [2];
    logic        acc [2];
    logic [15:0] bv  [2];

    logic        c_wr_en;
    logic [4:0]  c_wr_addr, c_rd_addr_a, c_rd_addr_b, c_rsv_addr;
    logic [31:0] c_wr_data, c_rd_data_a, c_rd_data_b, c_busy_vec;
    logic        c_rsv_en, c_rd_busy_a, c_rd_busy_b, c_rsv_accept;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: config 0 = plain/bypass, config 1 = zero-reg/no-bypass.
    logic [15:0] mem  [2][16];
    bit          busy [2][16];

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda[0]), .rd_busy_a(bza[0]),
        .rd_addr_b(rd_addr_b), .rd_data_b(rdb[0]), .rd_busy_b(bzb[0]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_accept(acc[0]), .busy_vec(bv[0])
    );

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda[1]), .rd_busy_a(bza[1]),
        .rd_addr_b(rd_addr_b), .rd_data_b(rdb[1]), .rd_busy_b(bzb[1]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_accept(acc[1]), .busy_vec(bv[1])
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut2 (
        .clk(clk), .reset(reset), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .rd_addr_a(c_rd_addr_a), .rd_data_a(c_rd_data_a), .rd_busy_a(c_rd_busy_a),
        .rd_addr_b(c_rd_addr_b), .rd_data_b(c_rd_data_b), .rd_busy_b(c_rd_busy_b),
        .rsv_en(c_rsv_en), .rsv_addr(c_rsv_addr), .rsv_accept(c_rsv_accept), .busy_vec(c_busy_vec)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_rd(input int c, input logic [3:0] a);
        if (c == 1 && a == 4'd0) return 16'h0000;
        if (c == 0 && wr_en && wr_addr == a) return wr_data;
        return mem[c][a];
    endfunction

    function automatic logic exp_acc(input int c);
        if (!rsv_en) return 1'b0;
        if (c == 1 && rsv_addr == 4'd0) return 1'b1;
        return !busy[c][rsv_addr] || (wr_en && wr_addr == rsv_addr);
    endfunction

    function automatic logic [15:0] exp_bv(input int c);
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = busy[c][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 16; i++) begin
                mem[c][i]  = '0;
                busy[c][i] = 1'b0;
            end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            logic a;
            a = exp_acc(c);
            if (wr_en) begin
                if (!(c == 1 && wr_addr == 4'd0)) mem[c][wr_addr] = wr_data;
                busy[c][wr_addr] = 1'b0;
            end
            if (a && !(c == 1 && rsv_addr == 4'd0)) busy[c][rsv_addr] = 1'b1;
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 2; c++) begin
            check($sformatf("c%0d rd_data_a", c), 64'(rda[c]), 64'(exp_rd(c, rd_addr_a)));
            check($sformatf("c%0d rd_data_b", c), 64'(rdb[c]), 64'(exp_rd(c, rd_addr_b)));
            check($sformatf("c%0d rd_busy_a", c), 64'(bza[c]), 64'(busy[c][rd_addr_a]));
            check($sformatf("c%0d rd_busy_b", c), 64'(bzb[c]), 64'(busy[c][rd_addr_b]));
            check($sformatf("c%0d rsv_accept", c), 64'(acc[c]), 64'(exp_acc(c)));
            check($sformatf("c%0d busy_vec", c), 64'(bv[c]), 64'(exp_bv(c)));
        end
    endtask

    // Drive one cycle's inputs after posedge, check before the falling edge.
    task automatic step(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic re, input logic [3:0] rsa);
        @(posedge clk);
        #1;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr_a = ra; rd_addr_b = rb;
        rsv_en = re; rsv_addr = rsa;
        #1;
        check_all();
        if (reset) model_edge();
    endtask

    initial begin
        reset = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; rsv_en = 1'b0; rsv_addr = '0;
        c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0;
        c_rd_addr_a = '0; c_rd_addr_b = '0; c_rsv_en = 1'b0; c_rsv_addr = '0;
        model_reset();

        // Reset state, then async reset in mid-cycle
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        step(0, 0, 0, 4'd1, 4'd15, 0, 0);
        step(1, 5, 16'h1234, 4'd5, 4'd2, 1, 4'd6);
        step(0, 0, 0, 4'd5, 4'd6, 0, 0);
        check("preload r5", 64'(rda[0]), 64'h1234);
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        check("reset r5 now", 64'(rda[0]), 64'h0);
        check("reset busy now", 64'(bv[0]), 64'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Write then dual read, and bypass versus no bypass
        step(1, 3, 16'hBEEF, 4'd0, 4'd0, 0, 0);
        step(0, 0, 0, 4'd3, 4'd3, 0, 0);
        check("r3 port a", 64'(rda[0]), 64'hBEEF);
        check("r3 port b", 64'(rdb[0]), 64'hBEEF);
        check("r3 nobyp a", 64'(rda[1]), 64'hBEEF);
        step(1, 7, 16'h00FF, 4'd7, 4'd3, 0, 0);
        check("bypass r7", 64'(rda[0]), 64'h00FF);
        check("nobypass r7 old", 64'(rda[1]), 64'h0000);
        step(0, 0, 0, 4'd7, 4'd7, 0, 0);
        check("nobypass r7 after", 64'(rda[1]), 64'h00FF);

        // Zero register
        step(1, 0, 16'hFFFF, 4'd0, 4'd0, 0, 0);
        step(0, 0, 0, 4'd0, 4'd0, 1, 4'd0);
        check("zero r0 read", 64'(rda[1]), 64'h0);
        check("plain r0 read", 64'(rda[0]), 64'hFFFF);
        check("zero r0 accept", 64'(acc[1]), 64'h1);
        step(0, 0, 0, 4'd0, 4'd0, 0, 0);
        check("zero r0 busy", 64'(bv[1][0]), 64'h0);

        // Scoreboard reserve / refuse / clear
        step(0, 0, 0, 4'd4, 4'd4, 1, 4'd4);
        check("rsv r4 accept", 64'(acc[1]), 64'h1);
        step(0, 0, 0, 4'd4, 4'd4, 1, 4'd4);
        check("rsv r4 again", 64'(acc[1]), 64'h0);
        check("busy r4 vec", 64'(bv[1]), 64'h0010);
        step(1, 4, 16'h0042, 4'd4, 4'd0, 0, 0);
        step(0, 0, 0, 4'd4, 4'd4, 0, 0);
        check("r4 cleared", 64'(bza[1]), 64'h0);
        check("r4 data", 64'(rda[1]), 64'h0042);

        // Write and re-reserve of a busy register in the same cycle
        step(0, 0, 0, 4'd9, 4'd9, 1, 4'd9);
        step(1, 9, 16'h5A5A, 4'd9, 4'd9, 1, 4'd9);
        check("r9 rereserve", 64'(acc[0]), 64'h1);
        step(0, 0, 0, 4'd9, 4'd9, 0, 0);
        check("r9 data", 64'(rda[1]), 64'h5A5A);
        check("r9 still busy", 64'(bv[1][9]), 64'h1);

        // Random traffic, addresses narrowed so reservations collide often
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 16'($urandom),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));
        end

        // 32-bit, 32-entry instance
        @(posedge clk);
        #1;
        c_wr_en = 1'b1; c_wr_addr = 5'd31; c_wr_data = 32'hDEADBEEF; c_rd_addr_a = 5'd31;
        #1;
        check("w32 bypass", 64'(c_rd_data_a), 64'hDEADBEEF);
        @(posedge clk);
        #1;
        c_wr_en = 1'b0; c_rsv_en = 1'b1; c_rsv_addr = 5'd30; c_rd_addr_b = 5'd30;
        #1;
        check("w32 accept", 64'(c_rsv_accept), 64'h1);
        @(posedge clk);
        #1;
        c_rsv_en = 1'b0;
        #1;
        check("w32 r31", 64'(c_rd_data_a), 64'hDEADBEEF);
        check("w32 busy_vec", 64'(c_busy_vec), 64'h4000_0000);
        check("w32 busy r30", 64'(c_rd_busy_b), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
